// File: rtl/polling_ts_rx_tracker.sv
// Receive-side TS1/TS2 run tracker for the LTSSM Polling substates.
// Counts consecutive qualifying ordered sets per lane and flags the Polling exit conditions.
module polling_ts_rx_tracker #(
  parameter int NUM_LANES    = 4,
  parameter int COUNT_TARGET = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [NUM_LANES-1:0] lanes_w_detected_load_i,
  input  logic [NUM_LANES-1:0] os_valid_i,
  input  logic [NUM_LANES-1:0] os_is_ts2_i,
  input  logic [NUM_LANES-1:0] os_pad_i,
  input  logic [NUM_LANES-1:0] os_compliance_i,
  input  logic [NUM_LANES-1:0] os_err_i,
  output logic [1:0]           state_o,
  output logic                 active_done_o,
  output logic                 compliance_req_o,
  output logic                 config_done_o,
  output logic [NUM_LANES-1:0] lane_ts_seen_o
);

  localparam int CW = $clog2(COUNT_TARGET + 1);
  localparam logic [CW-1:0] TARGET = CW'(COUNT_TARGET);

  typedef enum logic [1:0] {IDLE = 2'd0, ACT = 2'd1, CFG = 2'd2, DONE = 2'd3} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        match_cnt_q [NUM_LANES];
  logic [CW-1:0]        match_cnt_d [NUM_LANES];
  logic [CW-1:0]        comp_cnt_q  [NUM_LANES];
  logic [CW-1:0]        comp_cnt_d  [NUM_LANES];
  logic [NUM_LANES-1:0] seen_q, seen_d;
  logic                 active_done_q, active_done_d;
  logic                 comp_req_q, comp_req_d;
  logic                 config_done_q, config_done_d;
  logic                 all_reached, any_comp, in_act, in_cfg, qual;

  // Per-lane counts are updated first; the reductions look at the updated counts so a
  // transition lands on the same edge that samples the final qualifying ordered set.
  always_comb begin
    state_d       = state_q;
    seen_d        = seen_q;
    comp_req_d    = comp_req_q;
    active_done_d = 1'b0;
    in_act        = (state_q == ACT);
    in_cfg        = (state_q == CFG);
    qual          = 1'b0;
    all_reached   = |lanes_w_detected_load_i;
    any_comp      = 1'b0;

    for (int l = 0; l < NUM_LANES; l++) begin
      match_cnt_d[l] = match_cnt_q[l];
      comp_cnt_d[l]  = comp_cnt_q[l];
      if (os_valid_i[l] && (in_act || in_cfg)) begin
        qual = in_act ? (os_pad_i[l] && !os_compliance_i[l] && !os_err_i[l])
                      : (os_is_ts2_i[l] && os_pad_i[l] && !os_err_i[l]);
        if (!qual)
          match_cnt_d[l] = '0;
        else if (match_cnt_q[l] != TARGET)
          match_cnt_d[l] = match_cnt_q[l] + CW'(1);
        if (!(in_act && !os_is_ts2_i[l] && os_compliance_i[l] && !os_err_i[l]))
          comp_cnt_d[l] = '0;
        else if (comp_cnt_q[l] != TARGET)
          comp_cnt_d[l] = comp_cnt_q[l] + CW'(1);
      end
      if (os_valid_i[l] && !os_err_i[l] && (state_q != IDLE))
        seen_d[l] = 1'b1;
      if (lanes_w_detected_load_i[l] && (match_cnt_d[l] != TARGET))
        all_reached = 1'b0;
      if (lanes_w_detected_load_i[l] && (comp_cnt_d[l] == TARGET))
        any_comp = 1'b1;
    end

    case (state_q)
      IDLE: state_d = ACT;
      ACT: begin
        if (any_comp)
          comp_req_d = 1'b1;
        if (all_reached) begin
          state_d       = CFG;
          active_done_d = 1'b1;
          for (int l = 0; l < NUM_LANES; l++) match_cnt_d[l] = '0;
        end
      end
      CFG: if (all_reached) state_d = DONE;
      default: state_d = DONE;
    endcase

    // Dropping enable abandons the whole Polling attempt, whatever else happened this cycle.
    if (!en_i) begin
      state_d       = IDLE;
      seen_d        = '0;
      comp_req_d    = 1'b0;
      active_done_d = 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        match_cnt_d[l] = '0;
        comp_cnt_d[l]  = '0;
      end
    end

    config_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      seen_q        <= '0;
      active_done_q <= 1'b0;
      comp_req_q    <= 1'b0;
      config_done_q <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) begin
        match_cnt_q[l] <= '0;
        comp_cnt_q[l]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      seen_q        <= seen_d;
      active_done_q <= active_done_d;
      comp_req_q    <= comp_req_d;
      config_done_q <= config_done_d;
      for (int l = 0; l < NUM_LANES; l++) begin
        match_cnt_q[l] <= match_cnt_d[l];
        comp_cnt_q[l]  <= comp_cnt_d[l];
      end
    end
  end

  assign state_o          = state_q;
  assign active_done_o    = active_done_q;
  assign compliance_req_o = comp_req_q;
  assign config_done_o    = config_done_q;
  assign lane_ts_seen_o   = seen_q;

endmodule

// File: tb/tb_polling_ts_rx_tracker.sv
// Bench for polling_ts_rx_tracker: directed Polling scenarios then random traffic,
// every cycle compared against a run-length reference model.
module tb_polling_ts_rx_tracker;

  localparam int NL  = 4;
  localparam int TGT = 8;

  logic          clk = 1'b0;
  logic          rstN, en;
  logic [NL-1:0] mask, valid, ts2, pad, comp, err;
  logic [1:0]    stateO;
  logic          activeDoneO, complianceReqO, configDoneO;
  logic [NL-1:0] laneSeenO;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model: plain unbounded run lengths per lane, state as an integer 0..3.
  int            mState;
  int            mRun [NL];
  int            mComp [NL];
  logic [NL-1:0] mSeen;
  logic          mCompReq, mActDone;

  polling_ts_rx_tracker #(.NUM_LANES(NL), .COUNT_TARGET(TGT)) dut (
    .clk_i                   (clk),
    .rst_ni                  (rstN),
    .en_i                    (en),
    .lanes_w_detected_load_i (mask),
    .os_valid_i              (valid),
    .os_is_ts2_i             (ts2),
    .os_pad_i                (pad),
    .os_compliance_i         (comp),
    .os_err_i                (err),
    .state_o                 (stateO),
    .active_done_o           (activeDoneO),
    .compliance_req_o        (complianceReqO),
    .config_done_o           (configDoneO),
    .lane_ts_seen_o          (laneSeenO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic modelStep();
    bit ok, reached;
    mActDone = 1'b0;
    if (!rstN || !en) begin
      mState = 0; mSeen = '0; mCompReq = 1'b0;
      for (int l = 0; l < NL; l++) begin mRun[l] = 0; mComp[l] = 0; end
    end else if (mState == 0) begin
      mState = 1;
    end else begin
      for (int l = 0; l < NL; l++) if (valid[l] && !err[l]) mSeen[l] = 1'b1;
      if (mState != 3) begin
        for (int l = 0; l < NL; l++) if (valid[l]) begin
          ok = (mState == 1) ? (pad[l] && !comp[l] && !err[l]) : (ts2[l] && pad[l] && !err[l]);
          mRun[l]  = ok ? mRun[l] + 1 : 0;
          mComp[l] = (mState == 1 && !ts2[l] && comp[l] && !err[l]) ? mComp[l] + 1 : 0;
        end
        reached = (mask != 0);
        for (int l = 0; l < NL; l++) if (mask[l] && mRun[l] < TGT) reached = 0;
        if (mState == 1) begin
          for (int l = 0; l < NL; l++) if (mask[l] && mComp[l] >= TGT) mCompReq = 1'b1;
          if (reached) begin
            mState = 2; mActDone = 1'b1;
            for (int l = 0; l < NL; l++) mRun[l] = 0;
          end
        end else if (reached) begin
          mState = 3;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [NL-1:0] m,
                               input logic [NL-1:0] v, input logic [NL-1:0] t2,
                               input logic [NL-1:0] p, input logic [NL-1:0] c,
                               input logic [NL-1:0] er);
    rstN = r; en = e; mask = m; valid = v; ts2 = t2; pad = p; comp = c; err = er;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("state", 32'(stateO), 32'(mState));
    checkOutput("active_done", 32'(activeDoneO), 32'(mActDone));
    checkOutput("compliance_req", 32'(complianceReqO), 32'(mCompReq));
    checkOutput("config_done", 32'(configDoneO), 32'(mState == 3));
    checkOutput("lane_ts_seen", 32'(laneSeenO), 32'(mSeen));
  endtask

  // Sends n consecutive strobes on the lanes in v, all with the same attributes.
  task automatic sendRun(input logic [NL-1:0] m, input logic [NL-1:0] v, input int n,
                         input logic t2, input logic c, input logic er);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, 1'b1, m, v, {NL{t2}}, 4'hF, {NL{c}}, {NL{er}});
  endtask

  task automatic restart(input logic [NL-1:0] m);
    applyStimulus(1'b1, 1'b0, m, '0, '0, '0, '0, '0);
    applyStimulus(1'b1, 1'b1, m, '0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [NL-1:0] rv, rt, rp, rc, re, rm;
    rm = 4'hF;
    applyStimulus(1'b0, 1'b0, 4'hF, '0, '0, '0, '0, '0);
    checkOutput("reset state", 32'(stateO), 32'd0);

    // Full ACT -> CFG -> DONE on all four lanes.
    restart(4'hF);
    sendRun(4'hF, 4'hF, 7, 1'b0, 1'b0, 1'b0);
    checkOutput("act after 7", 32'(stateO), 32'd1);
    sendRun(4'hF, 4'hF, 1, 1'b0, 1'b0, 1'b0);
    checkOutput("act->cfg state", 32'(stateO), 32'd2);
    checkOutput("act->cfg pulse", 32'(activeDoneO), 32'd1);
    sendRun(4'hF, 4'hF, 8, 1'b1, 1'b0, 1'b0);
    checkOutput("cfg->done", 32'(configDoneO), 32'd1);

    // Partial mask; lanes 2-3 silent.
    restart(4'h3);
    sendRun(4'h3, 4'h3, 8, 1'b0, 1'b0, 1'b0);
    checkOutput("mask 0011 cfg", 32'(stateO), 32'd2);

    // Lane 3 never sends: no transition.
    restart(4'hF);
    sendRun(4'hF, 4'h7, 10, 1'b0, 1'b0, 1'b0);
    checkOutput("lane3 silent", 32'(stateO), 32'd1);

    // Errored OS on lane 1 breaks its run.
    restart(4'h2);
    sendRun(4'h2, 4'h2, 7, 1'b0, 1'b0, 1'b0);
    sendRun(4'h2, 4'h2, 1, 1'b0, 1'b0, 1'b1);
    sendRun(4'h2, 4'h2, 7, 1'b0, 1'b0, 1'b0);
    checkOutput("err break hold", 32'(stateO), 32'd1);
    sendRun(4'h2, 4'h2, 1, 1'b0, 1'b0, 1'b0);
    checkOutput("err break cfg", 32'(stateO), 32'd2);

    // TS1 in CFG breaks the TS2 run.
    sendRun(4'h2, 4'h2, 5, 1'b1, 1'b0, 1'b0);
    sendRun(4'h2, 4'h2, 1, 1'b0, 1'b0, 1'b0);
    sendRun(4'h2, 4'h2, 7, 1'b1, 1'b0, 1'b0);
    checkOutput("ts1 break hold", 32'(stateO), 32'd2);
    sendRun(4'h2, 4'h2, 1, 1'b1, 1'b0, 1'b0);
    checkOutput("ts1 break done", 32'(stateO), 32'd3);

    // Compliance request on lane 2, then enable drop.
    restart(4'hF);
    sendRun(4'hF, 4'h4, 8, 1'b0, 1'b1, 1'b0);
    checkOutput("compliance req", 32'(complianceReqO), 32'd1);
    checkOutput("compliance state", 32'(stateO), 32'd1);
    applyStimulus(1'b1, 1'b0, 4'hF, '0, '0, '0, '0, '0);
    checkOutput("en drop flags", 32'({complianceReqO, laneSeenO}), 32'd0);

    // Reset mid-run discards partial counts.
    restart(4'hF);
    sendRun(4'hF, 4'hF, 6, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'hF, 4'hF, '0, 4'hF, '0, '0);
    checkOutput("reset mid-run", 32'(stateO), 32'd0);
    applyStimulus(1'b1, 1'b1, 4'hF, '0, '0, '0, '0, '0);
    sendRun(4'hF, 4'hF, 7, 1'b0, 1'b0, 1'b0);
    checkOutput("fresh run hold", 32'(stateO), 32'd1);
    sendRun(4'hF, 4'hF, 1, 1'b0, 1'b0, 1'b0);
    checkOutput("fresh run cfg", 32'(stateO), 32'd2);

    // Random traffic biased toward completing runs.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(0, 99) < 2) rm = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      for (int l = 0; l < NL; l++) begin
        rv[l] = ($urandom_range(0, 99) < 70);
        rt[l] = (mState == 2) ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 30);
        rp[l] = ($urandom_range(0, 99) < 96);
        rc[l] = ($urandom_range(0, 99) < ((mState == 1 && l == 2) ? 40 : 3));
        re[l] = ($urandom_range(0, 99) < 3);
      end
      applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 99) >= 2, rm, rv, rt, rp, rc, re);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
